// File: rtl/wb_pkg.sv
// Shared encodings and defaults for the MEM/WB write-back stage.
package wb_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_ADDR_DEF = 5;

   // Write-back source select; 2'b11 is reserved and behaves as ALU.
   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_LOAD = 2'b01,
      WB_SEL_LINK = 2'b10,
      WB_SEL_RSVD = 2'b11
   } wb_sel_e;

   // Load width/sign encodings; unlisted codes behave as LW.
   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LBU = 3'b001,
      LD_LH  = 3'b010,
      LD_LHU = 3'b011,
      LD_LW  = 3'b100
   } ld_type_e;

   // True for the two halfword load codes.
   function automatic logic ld_is_half(input logic [2:0] ld);
      return (ld == LD_LH) || (ld == LD_LHU);
   endfunction

   // True for the two byte load codes.
   function automatic logic ld_is_byte(input logic [2:0] ld);
      return (ld == LD_LB) || (ld == LD_LBU);
   endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bus bundle between the memory stage (master) and the write-back stage (slave).
interface wb_stage_if
   import wb_pkg::*;
#(
   parameter int NB_DATA  = NB_DATA_DEF,
   parameter int NB_ADDR  = NB_ADDR_DEF,
   parameter int NB_COUNT = 32
);
   logic                i_valid;
   logic                i_stall;
   logic                i_flush;
   logic                i_reg_write;
   logic [1:0]          i_wb_sel;
   logic [2:0]          i_load_type;
   logic [NB_ADDR-1:0]  i_addres_rd;
   logic [NB_DATA-1:0]  i_alu_result;
   logic [NB_DATA-1:0]  i_mem_data;
   logic [NB_DATA-1:0]  i_link;
   logic                i_cnt_clr;
   logic                o_wenable;
   logic [NB_ADDR-1:0]  o_addres_rd;
   logic [NB_DATA-1:0]  o_data_rd;
   logic                o_valid;
   logic                o_misaligned;
   logic [NB_COUNT-1:0] o_retired;

   modport master (
      output i_valid, i_stall, i_flush, i_reg_write, i_wb_sel, i_load_type,
             i_addres_rd, i_alu_result, i_mem_data, i_link, i_cnt_clr,
      input  o_wenable, o_addres_rd, o_data_rd, o_valid, o_misaligned, o_retired
   );

   modport slave (
      input  i_valid, i_stall, i_flush, i_reg_write, i_wb_sel, i_load_type,
             i_addres_rd, i_alu_result, i_mem_data, i_link, i_cnt_clr,
      output o_wenable, o_addres_rd, o_data_rd, o_valid, o_misaligned, o_retired
   );
endinterface

// File: rtl/wb_stage_load_align.sv
// Little-endian byte/halfword extraction with sign or zero extension.
// Only meaningful for a 32-bit word; misaligned accesses still return the
// extraction for the offset truncated to the access size.
module load_align
   import wb_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF
) (
   input  logic [2:0]         load_type_i,
   input  logic [1:0]         offset_i,
   input  logic [NB_DATA-1:0] word_i,
   output logic [NB_DATA-1:0] data_o,
   output logic               misaligned_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte and halfword out of the aligned word.
   always_comb begin
      byte_s = word_i[{offset_i, 3'b000} +: 8];
      if (offset_i[1]) begin
         half_s = word_i[31:16];
      end else begin
         half_s = word_i[15:0];
      end
   end

   // Extend the selected field and flag accesses that straddle their size.
   always_comb begin
      data_o       = word_i;
      misaligned_o = 1'b0;
      case (load_type_i)
         LD_LB:   data_o = {{(NB_DATA-8){byte_s[7]}}, byte_s};
         LD_LBU:  data_o = {{(NB_DATA-8){1'b0}}, byte_s};
         LD_LH:   data_o = {{(NB_DATA-16){half_s[15]}}, half_s};
         LD_LHU:  data_o = {{(NB_DATA-16){1'b0}}, half_s};
         default: data_o = word_i;
      endcase
      if (ld_is_half(load_type_i)) begin
         misaligned_o = offset_i[0];
      end else if (ld_is_byte(load_type_i)) begin
         misaligned_o = 1'b0;
      end else begin
         misaligned_o = (offset_i != 2'b00);
      end
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back mux driving the register-file
// write port, with misaligned-load flagging and a retired-instruction count.
module wb_stage
   import wb_pkg::*;
#(
   parameter int NB_DATA  = NB_DATA_DEF,
   parameter int NB_ADDR  = NB_ADDR_DEF,
   parameter int NB_COUNT = 32
) (
   input  logic       clk,
   input  logic       rst,
   wb_stage_if.slave  bus
);

   logic [NB_DATA-1:0]  ld_data_s;
   logic                ld_mis_s;
   logic [NB_DATA-1:0]  wr_data_s;
   logic                mis_s;
   logic                wen_s;

   logic                valid_d,  valid_q;
   logic                wen_d,    wen_q;
   logic                mis_d,    mis_q;
   logic [NB_ADDR-1:0]  rd_d,     rd_q;
   logic [NB_DATA-1:0]  data_d,   data_q;
   logic [NB_COUNT-1:0] cnt_d,    cnt_q;

   load_align #(.NB_DATA(NB_DATA)) u_load_align (
      .load_type_i  (bus.i_load_type),
      .offset_i     (bus.i_alu_result[1:0]),
      .word_i       (bus.i_mem_data),
      .data_o       (ld_data_s),
      .misaligned_o (ld_mis_s)
   );

   // Select the write-back source and qualify the register-file write.
   always_comb begin
      case (bus.i_wb_sel)
         WB_SEL_LOAD: wr_data_s = ld_data_s;
         WB_SEL_LINK: wr_data_s = bus.i_link;
         default:     wr_data_s = bus.i_alu_result;
      endcase
      mis_s = bus.i_valid & (bus.i_wb_sel == WB_SEL_LOAD) & ld_mis_s;
      wen_s = bus.i_valid & bus.i_reg_write
            & (bus.i_addres_rd != {NB_ADDR{1'b0}}) & ~mis_s;
   end

   // Next-state: flush beats stall beats capture; clear beats increment.
   always_comb begin
      valid_d = valid_q;
      wen_d   = wen_q;
      mis_d   = 1'b0;
      rd_d    = rd_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (bus.i_flush) begin
         valid_d = 1'b0;
         wen_d   = 1'b0;
         rd_d    = {NB_ADDR{1'b0}};
         data_d  = {NB_DATA{1'b0}};
      end else if (bus.i_stall) begin
         // Held write is idempotent; the misaligned pulse must not repeat.
         mis_d = 1'b0;
      end else begin
         valid_d = bus.i_valid;
         wen_d   = wen_s;
         mis_d   = mis_s;
         rd_d    = bus.i_addres_rd;
         data_d  = wr_data_s;
         if (bus.i_valid) begin
            cnt_d = cnt_q + NB_COUNT'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end
      if (bus.i_cnt_clr) begin
         cnt_d = {NB_COUNT{1'b0}};
      end else begin
         cnt_d = cnt_d;
      end
   end

   // Stage registers; reset discards any in-flight result immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         wen_q   <= 1'b0;
         mis_q   <= 1'b0;
         rd_q    <= {NB_ADDR{1'b0}};
         data_q  <= {NB_DATA{1'b0}};
         cnt_q   <= {NB_COUNT{1'b0}};
      end else begin
         valid_q <= valid_d;
         wen_q   <= wen_d;
         mis_q   <= mis_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_valid      = valid_q;
   assign bus.o_wenable    = wen_q;
   assign bus.o_misaligned = mis_q;
   assign bus.o_addres_rd  = rd_q;
   assign bus.o_data_rd    = data_q;
   assign bus.o_retired    = cnt_q;

endmodule
